// File: rtl/prog_loader_if.sv
// Byte-stream handshake between a frame source and the program loader.
interface prog_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed byte stream (length, data
// words, XOR checksum), writes the words into instruction memory and holds
// the CPU in reset until the frame verifies.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [15:0] MAX_WORDS = 16'd1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    prog_loader_if.slave rx,
    output logic         imem_we,
    output logic [31:0]  imem_addr,
    output logic [31:0]  imem_wdata,
    output logic         cpu_rst,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [15:0]  words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        ready;
    logic        accept;
    logic [15:0] len;
    logic [15:0] len_in;
    logic [7:0]  chk;
    logic [1:0]  byte_idx;
    logic [23:0] wbuf;

    assign rx.rx_ready = ready;
    assign accept      = ready & rx.rx_valid;
    // Full word count as it becomes known while LEN_HI is on the bus.
    assign len_in      = {rx.rx_data, len[7:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_nx = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                ready = 1'b1;
                if (rx.rx_valid) state_nx = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                ready = 1'b1;
                if (rx.rx_valid) begin
                    if (len_in > MAX_WORDS)   state_nx = ST_ERR;
                    else if (len_in == 16'd0) state_nx = ST_CHECK;
                    else                      state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                ready = 1'b1;
                if (rx.rx_valid && byte_idx == 2'd3 && (words_loaded + 16'd1) == len)
                    state_nx = ST_CHECK;
            end
            ST_CHECK: begin
                ready = 1'b1;
                if (rx.rx_valid) state_nx = (rx.rx_data == chk) ? ST_DONE : ST_ERR;
            end
            default: state_nx = ST_IDLE;
        endcase
        busy    = ready;
        cpu_rst = (state != ST_DONE);
        done    = (state == ST_DONE);
        err     = (state == ST_ERR);
    end

    // Datapath: checksum, length capture, word assembly and memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= '0;
            words_loaded <= '0;
            len          <= '0;
            chk          <= '0;
            byte_idx     <= '0;
            wbuf         <= '0;
        end else begin
            imem_we <= 1'b0;
            // Address moves on the edge that ends the write strobe.
            if (imem_we) imem_addr <= imem_addr + 32'd4;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        chk          <= '0;
                        words_loaded <= '0;
                        byte_idx     <= '0;
                        imem_addr    <= BASE_ADDR;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= rx.rx_data;
                        chk      <= chk ^ rx.rx_data;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= rx.rx_data;
                        chk       <= chk ^ rx.rx_data;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        chk      <= chk ^ rx.rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_wdata   <= {rx.rx_data, wbuf};
                            imem_we      <= 1'b1;
                            words_loaded <= words_loaded + 16'd1;
                        end else begin
                            // Little endian: earlier bytes shift toward bit 0.
                            wbuf <= {rx.rx_data, wbuf[23:8]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: two instances (default parameters and
// BASE_ADDR=0x100/MAX_WORDS=4) share stimulus through a select; each frame's
// expected writes and outcome are derived from the frame contents.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        we0, we1, cr0, cr1, bz0, bz1, dn0, dn1, er0, er1;
    logic [31:0] ad0, ad1, wd0, wd1;
    logic [15:0] wl0, wl1;

    logic        we, cpu_rst, busy, done, err, rx_ready;
    logic [31:0] addr, wdata;
    logic [15:0] words_loaded;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned we_count = 0;

    always #5 clk = ~clk;

    prog_loader_if bus0 ();
    prog_loader_if bus1 ();

    assign bus0.rx_data  = rx_data;
    assign bus1.rx_data  = rx_data;
    assign bus0.rx_valid = rx_valid & ~sel;
    assign bus1.rx_valid = rx_valid & sel;

    prog_loader u_dut0 (
        .clk(clk), .rst(rst), .start(start & ~sel), .rx(bus0),
        .imem_we(we0), .imem_addr(ad0), .imem_wdata(wd0), .cpu_rst(cr0),
        .busy(bz0), .done(dn0), .err(er0), .words_loaded(wl0)
    );

    prog_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(16'd4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start & sel), .rx(bus1),
        .imem_we(we1), .imem_addr(ad1), .imem_wdata(wd1), .cpu_rst(cr1),
        .busy(bz1), .done(dn1), .err(er1), .words_loaded(wl1)
    );

    assign we           = sel ? we1 : we0;
    assign addr         = sel ? ad1 : ad0;
    assign wdata        = sel ? wd1 : wd0;
    assign cpu_rst      = sel ? cr1 : cr0;
    assign busy         = sel ? bz1 : bz0;
    assign done         = sel ? dn1 : dn0;
    assign err          = sel ? er1 : er0;
    assign words_loaded = sel ? wl1 : wl0;
    assign rx_ready     = sel ? bus1.rx_ready : bus0.rx_ready;

    always @(posedge clk) if (we) we_count <= we_count + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sends one frame built from 'words' to the selected instance.
    // mode: 0 back to back, 1 valid toggling, 2 random valid.
    // stop_after >= 0 sends only that many bytes and skips the outcome checks.
    task automatic run_frame(input bit s, input logic [31:0] words[$], input bit corrupt,
                             input int mode, input int stop_after);
        logic [31:0] base;
        int unsigned maxw;
        int unsigned n;
        logic [7:0]  bytes[$];
        logic [7:0]  x;
        bit          len_err, ok, acc, tog, abort;
        int unsigned we_before;
        int          bi;
        base = s ? 32'h100 : 32'h0;
        maxw = s ? 4 : 1024;
        n    = words.size();
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        foreach (words[i]) begin
            logic [31:0] w;
            w = words[i];
            for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
        end
        x = '0;
        foreach (bytes[i]) x ^= bytes[i];
        if (corrupt) x ^= 8'h01;
        bytes.push_back(x);
        len_err = (n > maxw);
        ok      = !len_err && !corrupt;

        @(negedge clk);
        sel = s; start = 1'b1; rx_valid = 1'b0;
        we_before = we_count;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("start_ready", 32'(rx_ready), 1);
        check_eq("start_cpu_rst", 32'(cpu_rst), 1);
        check_eq("start_flags", {30'd0, done, err}, 0);
        check_eq("start_addr", addr, base);
        check_eq("start_words", 32'(words_loaded), 0);

        tog = 1'b0; abort = 1'b0;
        for (bi = 0; bi < bytes.size() && !abort; bi++) begin
            if (stop_after >= 0 && bi >= stop_after) break;
            acc = 1'b0;
            for (int c = 0; c < 100 && !acc; c++) begin
                @(negedge clk);
                rx_data = bytes[bi];
                tog = ~tog;
                case (mode)
                    0: rx_valid = 1'b1;
                    1: rx_valid = tog;
                    default: rx_valid = 1'($urandom_range(0, 1));
                endcase
                #1 acc = rx_valid && rx_ready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                check_eq("accept_timeout", 32'(acc), 1);
                abort = 1'b1;
            end else if (bi == 1 && len_err) begin
                check_eq("len_err", 32'(err), 1);
                check_eq("len_err_ready", 32'(rx_ready), 0);
                check_eq("len_err_done", 32'(done), 0);
                abort = 1'b1;
            end else if (bi >= 2 && bi < bytes.size() - 1 && ((bi - 2) % 4) == 3) begin
                int unsigned w;
                w = (bi - 2) / 4;
                check_eq("wr_we", 32'(we), 1);
                check_eq("wr_addr", addr, base + 4 * w);
                check_eq("wr_data", wdata, words[w]);
                check_eq("wr_count", 32'(words_loaded), w + 1);
            end else if (bi == bytes.size() - 1) begin
                check_eq("chk_done", 32'(done), 32'(ok));
                check_eq("chk_err", 32'(err), 32'(!ok));
                check_eq("chk_cpu_rst", 32'(cpu_rst), 32'(!ok));
                check_eq("chk_ready", 32'(rx_ready), 0);
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        if (stop_after >= 0) return;
        repeat (3) @(posedge clk);
        #1;
        check_eq("write_count", we_count - we_before, len_err ? 0 : n);
        check_eq("hold_done", 32'(done), 32'(ok));
        check_eq("hold_err", 32'(err), 32'(!ok));
        check_eq("final_words", 32'(words_loaded), len_err ? 0 : n);
        check_eq("final_busy", 32'(busy), 0);
    endtask

    task automatic check_idle(input logic [31:0] base);
        check_eq("idle_cpu_rst", 32'(cpu_rst), 1);
        check_eq("idle_ready", 32'(rx_ready), 0);
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_flags", {30'd0, done, err}, 0);
        check_eq("idle_addr", addr, base);
        check_eq("idle_words", 32'(words_loaded), 0);
        check_eq("idle_we", 32'(we), 0);
    endtask

    initial begin
        logic [31:0] w[$];
        rst = 1'b1; sel = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sel = 1'b0; #1;
        check_idle(32'h0);
        check_eq("reset_wdata", wdata, 0);
        sel = 1'b1; #1;
        check_idle(32'h100);

        w = '{32'h00A0_0093};
        run_frame(0, w, 0, 0, -1);
        run_frame(0, w, 1, 1, -1);

        w = {};
        for (int i = 0; i < 5; i++) w.push_back($urandom);
        run_frame(1, w, 0, 0, -1);

        w = {};
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        run_frame(1, w, 0, 2, -1);
        w = {};
        run_frame(1, w, 0, 0, -1);

        for (int i = 0; i < 3; i++) w.push_back($urandom);
        run_frame(0, w, 0, 0, 7);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle(32'h0);
        w = {};
        for (int i = 0; i < 2; i++) w.push_back($urandom);
        run_frame(0, w, 0, 2, -1);

        for (int f = 0; f < 20; f++) begin
            int unsigned n;
            n = $urandom_range(0, 6);
            w = {};
            for (int i = 0; i < n; i++) w.push_back($urandom);
            run_frame(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 3) == 0),
                      int'($urandom_range(0, 2)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
